// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit-count helper for the BCD converter.
package bcd_pkg;

    localparam int unsigned NIB_W    = 4;
    localparam logic [3:0]  BCD_NINE = 4'h9;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Number of decimal digits needed to print 2**bits-1.
    function automatic int unsigned bcd_digits(input int unsigned bits);
        longint unsigned v;
        int unsigned     d;
        v = (longint'(1) << bits) - longint'(1);
        d = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            d = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble that would overflow when doubled.
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib_c
);

    assign o_nib_c = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with saturation and leading-zero flags.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 7,
    parameter int unsigned DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [NIB_W*DIGITS-1:0]   bcd_out,
    output logic                      ovf,
    output logic [DIGITS-1:0]         lz_mask
);

    localparam int unsigned SCR_D = bcd_digits(BIN_W);
    localparam int unsigned SCR_W = SCR_D * NIB_W;
    localparam int unsigned OUT_W = DIGITS * NIB_W;
    localparam int unsigned EXT_D = (SCR_D > DIGITS) ? SCR_D : DIGITS;
    localparam int unsigned EXT_W = EXT_D * NIB_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_load;
    logic               w_shift;
    logic               w_last;

    logic [BIN_W-1:0]   r_bin;
    logic [SCR_W-1:0]   r_scr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [OUT_W-1:0]   r_bcd;
    logic               r_ovf;
    logic [DIGITS-1:0]  r_lz;

    logic [SCR_W-1:0]   w_adj;
    logic [SCR_W-1:0]   w_scr_shift;
    logic [BIN_W-1:0]   w_bin_shift;
    logic [EXT_W-1:0]   w_ext;
    logic               w_ovf;
    logic [DIGITS-1:0]  w_lz;

    // Per-digit add-3 correction applied before every shift
    for (genvar g = 0; g < SCR_D; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nib   (r_scr[g*NIB_W +: NIB_W]),
            .o_nib_c (w_adj[g*NIB_W +: NIB_W])
        );
    end

    assign w_scr_shift = {w_adj[SCR_W-2:0], r_bin[BIN_W-1]};
    assign w_bin_shift = {r_bin[BIN_W-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == CNT_W'(BIN_W - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Result derived from the scratch value produced by the final shift
    always_comb begin
        logic zero_run;
        w_ext    = EXT_W'(w_scr_shift);
        w_ovf    = |(w_ext >> OUT_W);
        w_lz     = '0;
        zero_run = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            zero_run = zero_run & (w_ext[i*NIB_W +: NIB_W] == 4'd0);
            w_lz[i]  = zero_run;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_scr  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_bcd  <= '0;
            r_ovf  <= 1'b0;
            r_lz   <= '0;
        end else begin
            r_busy <= (w_state_next != IDLE);
            r_done <= (w_state_next == DONE);
            if (w_load) begin
                r_bin <= bin_in;
                r_scr <= '0;
                r_cnt <= '0;
            end else if (w_shift) begin
                r_bin <= w_bin_shift;
                r_scr <= w_scr_shift;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_last) begin
                r_ovf <= w_ovf;
                r_bcd <= w_ovf ? {DIGITS{BCD_NINE}} : w_ext[OUT_W-1:0];
                r_lz  <= w_ovf ? '0 : w_lz;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bcd_out = r_bcd;
    assign ovf     = r_ovf;
    assign lz_mask = r_lz;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, exhaustive/random sweep, busy-time corners.
module tb_bin2bcd_seq;

    localparam int unsigned BIN_W  = 7;
    localparam int unsigned DIGITS = 2;
    localparam int          LAT    = BIN_W + 1;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [BIN_W-1:0]    bin_in = '0;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd_out;
    logic                ovf;
    logic [DIGITS-1:0]   lz_mask;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [6:0] bin;
        logic [7:0] bcd;
        logic       ovf;
        logic [1:0] lz;
    } vec_t;

    vec_t tbl[10];

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf),
        .lz_mask (lz_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain decimal arithmetic on the integer value
    task automatic model(input int v, output logic [7:0] b, output logic o, output logic [1:0] lz);
        if (v >= 100) begin
            b  = 8'h99;
            o  = 1'b1;
            lz = 2'b00;
        end else begin
            b  = {4'(v / 10), 4'(v % 10)};
            o  = 1'b0;
            lz = (v < 10) ? 2'b10 : 2'b00;
        end
    endtask

    task automatic run_conv(input logic [6:0] v, input logic [7:0] eb, input logic eo, input logic [1:0] el);
        int  lat;
        int  busy_n;
        bit  got;
        string tag;
        tag = $sformatf("bin=%0d", v);
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        lat    = 1;
        busy_n = 0;
        got    = 1'b0;
        @(negedge clk);
        start  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_n++;
            if (done) begin
                got = 1'b1;
                break;
            end
            bin_in = 7'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, " done_seen"}, 32'(got), 32'd1);
        chk({tag, " latency"},   32'(lat), 32'(LAT));
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'(LAT));
        chk({tag, " bcd_out"},   32'(bcd_out), 32'(eb));
        chk({tag, " ovf"},       32'(ovf), 32'(eo));
        chk({tag, " lz_mask"},   32'(lz_mask), 32'(el));
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, " busy_idle"}, 32'(busy), 32'd0);
        chk({tag, " bcd_hold"},  32'(bcd_out), 32'(eb));
    endtask

    initial begin
        logic [7:0] eb;
        logic       eo;
        logic [1:0] el;
        logic [7:0] cap;
        int         pulses;
        int         lat;
        int         gap;

        tbl[0] = '{7'd57,  8'h57, 1'b0, 2'b00};
        tbl[1] = '{7'd5,   8'h05, 1'b0, 2'b10};
        tbl[2] = '{7'd0,   8'h00, 1'b0, 2'b10};
        tbl[3] = '{7'd99,  8'h99, 1'b0, 2'b00};
        tbl[4] = '{7'd100, 8'h99, 1'b1, 2'b00};
        tbl[5] = '{7'd127, 8'h99, 1'b1, 2'b00};
        tbl[6] = '{7'd10,  8'h10, 1'b0, 2'b00};
        tbl[7] = '{7'd9,   8'h09, 1'b0, 2'b10};
        tbl[8] = '{7'd64,  8'h64, 1'b0, 2'b00};
        tbl[9] = '{7'd1,   8'h01, 1'b0, 2'b10};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset busy",    32'(busy),    32'd0);
        chk("reset done",    32'(done),    32'd0);
        chk("reset bcd_out", 32'(bcd_out), 32'h00);
        chk("reset ovf",     32'(ovf),     32'd0);
        chk("reset lz_mask", 32'(lz_mask), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_conv(tbl[i].bin, tbl[i].bcd, tbl[i].ovf, tbl[i].lz);
        end

        // Start pulses while busy are ignored, bin_in scrambled during busy
        @(negedge clk);
        start  = 1'b1;
        bin_in = 7'd42;
        @(posedge clk);
        pulses = 0;
        cap    = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                cap = bcd_out;
            end
            start  = (c == 2 || c == 7);
            bin_in = start ? 7'd13 : 7'($urandom);
        end
        start = 1'b0;
        chk("busy_start done_pulses", 32'(pulses), 32'd1);
        chk("busy_start bcd_out",     32'(cap),    32'h42);

        // Start held high: back-to-back conversions
        @(negedge clk);
        start  = 1'b1;
        bin_in = 7'd13;
        @(posedge clk);
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk);
            lat++;
        end
        chk("held first latency", 32'(lat), 32'(LAT));
        chk("held first bcd_out", 32'(bcd_out), 32'h13);
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            gap++;
            @(negedge clk);
            if (done) break;
        end
        chk("held done spacing", 32'(gap), 32'(BIN_W + 2));
        chk("held second bcd_out", 32'(bcd_out), 32'h13);
        start = 1'b0;
        for (int i = 0; i < 30 && busy; i++) @(negedge clk);
        chk("held returns idle", 32'(busy), 32'd0);

        // Reset mid-conversion aborts without a done pulse
        @(negedge clk);
        start  = 1'b1;
        bin_in = 7'd88;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy",    32'(busy),    32'd0);
        chk("abort done",    32'(done),    32'd0);
        chk("abort bcd_out", 32'(bcd_out), 32'h00);
        chk("abort ovf",     32'(ovf),     32'd0);
        chk("abort lz_mask", 32'(lz_mask), 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("abort no_done", 32'(pulses), 32'd0);
        run_conv(7'd10, 8'h10, 1'b0, 2'b00);

        // Exhaustive sweep against the reference model
        for (int v = 0; v < 128; v++) begin
            model(v, eb, eo, el);
            run_conv(7'(v), eb, eo, el);
        end

        // Random values against the reference model
        for (int n = 0; n < 20; n++) begin
            int v;
            v = int'($urandom_range(0, 127));
            model(v, eb, eo, el);
            run_conv(7'(v), eb, eo, el);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
